// File: rtl/turbo_rsc_encoder_if.sv
// Bit-stream bundle for one constituent RSC encoder.
//   Input side : dataIn, look_now_in, flag_long_in (driven by the master)
//   Output side: sys_out, par_out, valid_out, look_now_out, tail_out,
//                flag_long_out, overrun (driven by the encoder, the slave)
interface turbo_rsc_encoder_if;
  logic dataIn;
  logic look_now_in;
  logic flag_long_in;
  logic sys_out;
  logic par_out;
  logic valid_out;
  logic look_now_out;
  logic tail_out;
  logic flag_long_out;
  logic overrun;

  modport master (
    output dataIn, look_now_in, flag_long_in,
    input  sys_out, par_out, valid_out, look_now_out, tail_out,
           flag_long_out, overrun
  );

  modport slave (
    input  dataIn, look_now_in, flag_long_in,
    output sys_out, par_out, valid_out, look_now_out, tail_out,
           flag_long_out, overrun
  );
endinterface

// File: rtl/turbo_rsc_encoder.sv
// LTE turbo constituent RSC encoder (g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3).
// Takes one serial bit per clock for a K-bit block framed by look_now_in,
// then appends 3 tail cycles that flush the trellis back to state 000.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - slave side of turbo_rsc_encoder_if (serial input, registered
//           systematic/parity outputs with framing and overrun flag)
//
// state | meaning
// IDLE  | waiting for look_now_in; accepting it encodes bit 0
// DATA  | encoding bits 1..K-1, cnt_q = index of the bit being consumed
// TAIL  | 3 termination cycles, cnt_q = tail index 0..2
module turbo_rsc_encoder #(
  parameter int K_SHORT = 1056,
  parameter int K_LONG  = 6144,
  parameter int CNT_W   = 13
) (
  input  logic              clk,
  input  logic              reset,
  turbo_rsc_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_S   = CNT_W'(K_SHORT - 1);
  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(K_LONG - 1);
  localparam logic [CNT_W-1:0] TAIL_END = CNT_W'(2);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             s1_q, s2_q, s3_q;

  logic sys_q, par_q, valid_q, look_q, tail_q, ovr_q;
  logic sys_d, par_d, valid_d, look_d, tail_d, ovr_d;

  logic             accept, consume, is_tail;
  logic             c_bit, a_bit, z_bit;
  logic [CNT_W-1:0] k_last, k_last_new;

  assign accept     = (state_q == IDLE) && bus.look_now_in;
  assign is_tail    = (state_q == TAIL);
  assign consume    = accept || (state_q == DATA) || is_tail;
  assign k_last     = flag_q ? LAST_L : LAST_S;
  assign k_last_new = bus.flag_long_in ? LAST_L : LAST_S;

  // Tail input is chosen so the feedback bit a becomes 0, draining the state.
  assign c_bit = is_tail ? (s2_q ^ s3_q) : bus.dataIn;
  assign a_bit = c_bit ^ s2_q ^ s3_q;
  assign z_bit = a_bit ^ s1_q ^ s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      sys_q   <= 1'b0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      look_q  <= 1'b0;
      tail_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      if (consume) begin
        s1_q <= a_bit;
        s2_q <= s1_q;
        s3_q <= s2_q;
      end
      sys_q   <= sys_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      look_q  <= look_d;
      tail_q  <= tail_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (bus.look_now_in) begin
          flag_d = bus.flag_long_in;
          if (k_last_new == '0) begin
            state_d = TAIL;
            cnt_d   = '0;
          end else begin
            state_d = DATA;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (cnt_q == k_last) begin
          state_d = TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt_q == TAIL_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    valid_d = consume;
    sys_d   = consume ? c_bit : 1'b0;
    par_d   = consume ? z_bit : 1'b0;
    look_d  = accept;
    tail_d  = is_tail;
    ovr_d   = bus.look_now_in && (state_q != IDLE);
  end

  assign bus.sys_out       = sys_q;
  assign bus.par_out       = par_q;
  assign bus.valid_out     = valid_q;
  assign bus.look_now_out  = look_q;
  assign bus.tail_out      = tail_q;
  assign bus.flag_long_out = flag_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
module tb_turbo_rsc_encoder;
  localparam int KS = 1056;
  localparam int KL = 6144;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  turbo_rsc_encoder_if bus ();

  turbo_rsc_encoder #(.K_SHORT(KS), .K_LONG(KL), .CNT_W(13)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        sys;
    logic        par;
    logic        lnow;
    logic        tail;
    logic        flag;
    logic        ovr;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   mon_hold = 1'b1;
  bit   flag_hold = 1'b0;
  bit   m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;

  // hand-derived: impulse parity for bits 0..4, tail after a lone final 1
  bit imp_par[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  bit tail_sys[3] = '{1'b0, 1'b1, 1'b1};
  bit tail_par[3] = '{1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (!mon_hold) begin
      if (bus.valid_out === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          if ({bus.sys_out, bus.par_out, bus.look_now_out, bus.tail_out,
               bus.flag_long_out, bus.overrun} !== {e.sys, e.par, e.lnow, e.tail, e.flag, e.ovr}
              || cyc != int'(e.cyc)) begin
            miscompares++;
            $display("FAIL out_bits cyc=%0d got sys,par,lnow,tail,flag,ovr=%b%b%b%b%b%b exp=%b%b%b%b%b%b at cyc=%0d",
                     cyc, bus.sys_out, bus.par_out, bus.look_now_out, bus.tail_out,
                     bus.flag_long_out, bus.overrun, e.sys, e.par, e.lnow, e.tail,
                     e.flag, e.ovr, e.cyc);
          end
          flag_hold = e.flag;
        end
      end else begin
        vectors++;
        if (bus.valid_out !== 1'b0 || bus.look_now_out !== 1'b0 || bus.tail_out !== 1'b0 ||
            bus.overrun !== 1'b0 || bus.flag_long_out !== flag_hold) begin
          miscompares++;
          $display("FAIL idle_outputs cyc=%0d got valid,lnow,tail,ovr,flag=%b%b%b%b%b exp=0000%b",
                   cyc, bus.valid_out, bus.look_now_out, bus.tail_out, bus.overrun,
                   bus.flag_long_out, flag_hold);
        end
      end
    end
  end

  task automatic model_step(input bit tl, input bit d, output bit x, output bit z);
    bit c, a;
    c = tl ? (m2 ^ m3) : d;
    a = c ^ m2 ^ m3;
    z = a ^ m1 ^ m3;
    x = c;
    m3 = m2;
    m2 = m1;
    m1 = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.look_now_in  = 1'b0;
      bus.dataIn       = 1'($urandom);
      bus.flag_long_in = 1'($urandom);
    end
  endtask

  // pattern: 0 all zero, 1 impulse at bit 0, 2 single 1 at bit k-1, 3 random
  task automatic run_block(input int k, input bit fl, input int pattern,
                           input int ovr_at, input int rst_at);
    bit   d, x, z;
    exp_t e;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      if (i == rst_at) begin
        reset = 1'b1;
        mon_hold = 1'b1;
        bus.look_now_in = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({bus.valid_out, bus.sys_out, bus.par_out, bus.look_now_out, bus.tail_out,
             bus.flag_long_out, bus.overrun} !== 7'b0) begin
          miscompares++;
          $display("FAIL reset_mid_block got valid,sys,par,lnow,tail,flag,ovr=%b%b%b%b%b%b%b exp=0000000",
                   bus.valid_out, bus.sys_out, bus.par_out, bus.look_now_out,
                   bus.tail_out, bus.flag_long_out, bus.overrun);
        end
        reset = 1'b0;
        sb.delete();
        m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
        flag_hold = 1'b0;
        mon_hold = 1'b0;
        return;
      end
      case (pattern)
        0:       d = 1'b0;
        1:       d = (i == 0);
        2:       d = (i == k - 1);
        default: d = 1'($urandom);
      endcase
      bus.dataIn       = d;
      bus.look_now_in  = (i == 0) || (i == ovr_at);
      bus.flag_long_in = (i == 0) ? fl : ~fl;
      model_step(1'b0, d, x, z);
      e = '{sys: x, par: z, lnow: (i == 0), tail: 1'b0, flag: fl,
            ovr: (i == ovr_at), cyc: 32'(cyc + 1)};
      if (pattern == 1 && i < 5) begin
        e.sys = (i == 0);
        e.par = imp_par[i];
      end
      if (pattern == 2 && i == k - 1) e.par = 1'b1;
      sb.push_back(e);
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      bus.dataIn       = 1'($urandom);
      bus.look_now_in  = 1'b0;
      bus.flag_long_in = 1'($urandom);
      model_step(1'b1, 1'b0, x, z);
      e = '{sys: x, par: z, lnow: 1'b0, tail: 1'b1, flag: fl, ovr: 1'b0,
            cyc: 32'(cyc + 1)};
      if (pattern == 2) begin
        e.sys = tail_sys[t];
        e.par = tail_par[t];
      end
      sb.push_back(e);
    end
  endtask

  initial begin
    bus.dataIn       = 1'b0;
    bus.look_now_in  = 1'b0;
    bus.flag_long_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    vectors++;
    if ({bus.valid_out, bus.sys_out, bus.par_out, bus.look_now_out, bus.tail_out,
         bus.flag_long_out, bus.overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state got valid,sys,par,lnow,tail,flag,ovr=%b%b%b%b%b%b%b exp=0000000",
               bus.valid_out, bus.sys_out, bus.par_out, bus.look_now_out,
               bus.tail_out, bus.flag_long_out, bus.overrun);
    end
    reset = 1'b0;
    mon_hold = 1'b0;

    idle(1);
    run_block(KS, 1'b0, 0, -1, -1);   // look_now_in consumed at cycle 5
    idle(4);
    run_block(KS, 1'b0, 1, -1, -1);
    idle(2);
    run_block(KS, 1'b0, 2, -1, -1);
    run_block(KS, 1'b0, 3, -1, -1);   // back-to-back, must start from 000
    idle(3);
    run_block(KL, 1'b1, 3, -1, -1);
    run_block(KS, 1'b0, 3, -1, -1);   // flag_long_out drops on first output
    idle(2);
    run_block(KS, 1'b0, 3, 500, -1);
    idle(2);
    run_block(KS, 1'b1, 3, -1, 300);
    idle(2);
    run_block(KS, 1'b0, 3, -1, -1);

    for (int n = 0; n < 20 && sb.size() != 0; n++) idle(1);
    idle(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending outputs exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
